seed_f_round: RTL and testbench

//   SEED round F-function, computed iteratively with one shared G-function datapath.
//   The G datapath instantiates SS0..SS3 (8-bit adrs -> 32-bit outSn) and XORs their outputs:
//     G(X) = SS3[X[31:24]] ^ SS2[X[23:16]] ^ SS1[X[15:8]] ^ SS0[X[7:0]].
//   The round controller feeds this block (C, D, Ki0, Ki1) and consumes (C', D') for the Feistel swap.

---
 rtl/seed_f_round.sv | 206 ++++++++++++++++++++
 tb/tb_seed_f_round.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seed_f_round.sv
// seed_f_round: SEED round F-function, iterated over three steps through one shared G datapath.
// Optional build macro SEED_F_REG_G_EN registers the G output (g_q) and splits each G step in two.
module seed_f_round (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] c_in,
   input  logic [31:0] d_in,
   input  logic [31:0] k0,
   input  logic [31:0] k1,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] c_out,
   output logic [31:0] d_out,
   output logic        busy
);
   localparam logic [7:0] M0 = 8'hfc;
   localparam logic [7:0] M1 = 8'hf3;
   localparam logic [7:0] M2 = 8'hcf;
   localparam logic [7:0] M3 = 8'h3f;

   localparam logic [7:0] S1 [256] = '{
      8'd169,8'd133,8'd214,8'd211,8'd84,8'd29,8'd172,8'd37,8'd93,8'd67,8'd24,8'd30,8'd81,8'd252,8'd202,8'd99,
      8'd40,8'd68,8'd32,8'd157,8'd224,8'd226,8'd200,8'd23,8'd165,8'd143,8'd3,8'd123,8'd187,8'd19,8'd210,8'd238,
      8'd112,8'd140,8'd63,8'd168,8'd50,8'd221,8'd246,8'd116,8'd236,8'd149,8'd11,8'd87,8'd92,8'd91,8'd189,8'd1,
      8'd36,8'd28,8'd115,8'd152,8'd16,8'd204,8'd242,8'd217,8'd44,8'd231,8'd114,8'd131,8'd155,8'd209,8'd134,8'd201,
      8'd96,8'd80,8'd163,8'd235,8'd13,8'd182,8'd158,8'd79,8'd183,8'd90,8'd198,8'd120,8'd166,8'd18,8'd175,8'd213,
      8'd97,8'd195,8'd180,8'd65,8'd82,8'd125,8'd141,8'd8,8'd31,8'd153,8'd0,8'd25,8'd4,8'd83,8'd247,8'd225,
      8'd253,8'd118,8'd47,8'd39,8'd176,8'd139,8'd14,8'd171,8'd162,8'd110,8'd147,8'd77,8'd105,8'd124,8'd9,8'd10,
      8'd191,8'd239,8'd243,8'd197,8'd135,8'd20,8'd254,8'd100,8'd222,8'd46,8'd75,8'd26,8'd6,8'd33,8'd107,8'd102,
      8'd2,8'd245,8'd146,8'd138,8'd12,8'd179,8'd126,8'd208,8'd122,8'd71,8'd150,8'd229,8'd38,8'd128,8'd173,8'd223,
      8'd161,8'd48,8'd55,8'd174,8'd54,8'd21,8'd34,8'd56,8'd244,8'd167,8'd69,8'd76,8'd129,8'd233,8'd132,8'd151,
      8'd53,8'd203,8'd206,8'd60,8'd113,8'd17,8'd199,8'd137,8'd117,8'd251,8'd218,8'd248,8'd148,8'd89,8'd130,8'd196,
      8'd255,8'd73,8'd57,8'd103,8'd192,8'd207,8'd215,8'd184,8'd15,8'd142,8'd66,8'd35,8'd145,8'd108,8'd219,8'd164,
      8'd52,8'd241,8'd72,8'd194,8'd111,8'd61,8'd45,8'd64,8'd190,8'd62,8'd188,8'd193,8'd170,8'd186,8'd78,8'd85,
      8'd59,8'd220,8'd104,8'd127,8'd156,8'd216,8'd74,8'd86,8'd119,8'd160,8'd237,8'd70,8'd181,8'd43,8'd101,8'd250,
      8'd227,8'd185,8'd177,8'd159,8'd94,8'd249,8'd230,8'd178,8'd49,8'd234,8'd109,8'd95,8'd228,8'd240,8'd205,8'd136,
      8'd22,8'd58,8'd88,8'd212,8'd98,8'd41,8'd7,8'd51,8'd232,8'd27,8'd5,8'd121,8'd144,8'd106,8'd42,8'd154};

   localparam logic [7:0] S2 [256] = '{
      8'd56,8'd232,8'd45,8'd166,8'd207,8'd222,8'd179,8'd184,8'd175,8'd96,8'd85,8'd199,8'd68,8'd111,8'd107,8'd91,
      8'd195,8'd98,8'd51,8'd181,8'd41,8'd160,8'd226,8'd167,8'd211,8'd145,8'd17,8'd6,8'd28,8'd188,8'd54,8'd75,
      8'd239,8'd136,8'd108,8'd168,8'd23,8'd196,8'd22,8'd244,8'd194,8'd69,8'd225,8'd214,8'd63,8'd61,8'd142,8'd152,
      8'd40,8'd78,8'd246,8'd62,8'd165,8'd249,8'd13,8'd223,8'd216,8'd43,8'd102,8'd122,8'd39,8'd47,8'd241,8'd114,
      8'd66,8'd212,8'd65,8'd192,8'd115,8'd103,8'd172,8'd139,8'd247,8'd173,8'd128,8'd31,8'd202,8'd44,8'd170,8'd52,
      8'd210,8'd11,8'd238,8'd233,8'd93,8'd148,8'd24,8'd248,8'd87,8'd174,8'd8,8'd197,8'd19,8'd205,8'd134,8'd185,
      8'd255,8'd125,8'd193,8'd49,8'd245,8'd138,8'd106,8'd177,8'd209,8'd32,8'd215,8'd2,8'd34,8'd4,8'd104,8'd113,
      8'd7,8'd219,8'd157,8'd153,8'd97,8'd190,8'd230,8'd89,8'd221,8'd81,8'd144,8'd220,8'd154,8'd163,8'd171,8'd208,
      8'd129,8'd15,8'd71,8'd26,8'd227,8'd236,8'd141,8'd191,8'd150,8'd123,8'd92,8'd162,8'd161,8'd99,8'd35,8'd77,
      8'd200,8'd158,8'd156,8'd58,8'd12,8'd46,8'd186,8'd110,8'd159,8'd90,8'd242,8'd146,8'd243,8'd73,8'd120,8'd204,
      8'd21,8'd251,8'd112,8'd117,8'd127,8'd53,8'd16,8'd3,8'd100,8'd109,8'd198,8'd116,8'd213,8'd180,8'd234,8'd9,
      8'd118,8'd25,8'd254,8'd64,8'd18,8'd224,8'd189,8'd5,8'd250,8'd1,8'd240,8'd42,8'd94,8'd169,8'd86,8'd67,
      8'd133,8'd20,8'd137,8'd155,8'd176,8'd229,8'd72,8'd121,8'd151,8'd252,8'd30,8'd130,8'd33,8'd140,8'd27,8'd95,
      8'd119,8'd84,8'd178,8'd29,8'd37,8'd79,8'd0,8'd70,8'd237,8'd88,8'd82,8'd235,8'd126,8'd218,8'd201,8'd253,
      8'd48,8'd149,8'd101,8'd60,8'd182,8'd228,8'd187,8'd124,8'd14,8'd80,8'd57,8'd38,8'd50,8'd132,8'd105,8'd147,
      8'd55,8'd231,8'd36,8'd164,8'd203,8'd83,8'd10,8'd135,8'd217,8'd76,8'd131,8'd143,8'd206,8'd59,8'd74,8'd183};

`ifdef SEED_F_REG_G_EN
   localparam logic [2:0] ST_IDLE = 3'd0, ST_G1A = 3'd1, ST_G1B = 3'd2, ST_G2A = 3'd3;
   localparam logic [2:0] ST_G2B  = 3'd4, ST_G3A = 3'd5, ST_G3B = 3'd6, ST_DONE = 3'd7;
`else
   localparam logic [2:0] ST_IDLE = 3'd0, ST_G1 = 3'd1, ST_G2 = 3'd2, ST_G3 = 3'd3, ST_DONE = 3'd4;
`endif

   // SS0..SS3 are the same S-box byte spread over the four lanes with rotated masks.
   function automatic logic [31:0] ss0(input logic [7:0] y);
      return {y & M3, y & M2, y & M1, y & M0};
   endfunction
   function automatic logic [31:0] ss1(input logic [7:0] y);
      return {y & M0, y & M3, y & M2, y & M1};
   endfunction
   function automatic logic [31:0] ss2(input logic [7:0] y);
      return {y & M1, y & M0, y & M3, y & M2};
   endfunction
   function automatic logic [31:0] ss3(input logic [7:0] y);
      return {y & M2, y & M1, y & M0, y & M3};
   endfunction
   function automatic logic [31:0] g_fn(input logic [31:0] x);
      return ss3(S2[x[31:24]]) ^ ss2(S1[x[23:16]]) ^ ss1(S2[x[15:8]]) ^ ss0(S1[x[7:0]]);
   endfunction

   logic [2:0]  state_q, state_d;
   logic [31:0] c_q, c_d, d_q, d_d, c_out_q, c_out_d, d_out_q, d_out_d;
   logic        out_valid_q, out_valid_d;
   logic        sel_d_s;
   logic [31:0] g_op_s, g_use_s;

`ifdef SEED_F_REG_G_EN
   logic [31:0] g_q, g_d;
   assign sel_d_s = (state_q == ST_G1A);
   assign g_use_s = g_q;

   // G result register, loaded in the first half of each G step
   always_comb begin
      g_d = g_q;
      if (state_q == ST_G1A || state_q == ST_G2A || state_q == ST_G3A) begin
         g_d = g_fn(g_op_s);
      end else begin
         g_d = g_q;
      end
   end

   // g_q storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_q <= 32'd0;
      end else begin
         g_q <= g_d;
      end
   end
`else
   assign sel_d_s = (state_q == ST_G1);
   assign g_use_s = g_fn(g_op_s);
`endif

   // Shared G operand: d_q in the first step, c_q + d_q (mod 2^32) in the other two
   always_comb begin
      if (sel_d_s) begin
         g_op_s = d_q;
      end else begin
         g_op_s = c_q + d_q;
      end
   end

   // Round sequencing and datapath updates
   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      d_d         = d_q;
      c_out_d     = c_out_q;
      d_out_d     = d_out_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               c_d     = c_in ^ k0;
               d_d     = (c_in ^ k0) ^ (d_in ^ k1);
`ifdef SEED_F_REG_G_EN
               state_d = ST_G1A;
`else
               state_d = ST_G1;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef SEED_F_REG_G_EN
         ST_G1A: state_d = ST_G1B;
         ST_G1B: begin d_d = g_use_s; state_d = ST_G2A; end
         ST_G2A: state_d = ST_G2B;
         ST_G2B: begin c_d = g_use_s; state_d = ST_G3A; end
         ST_G3A: state_d = ST_G3B;
         ST_G3B: begin
`else
         ST_G1: begin d_d = g_use_s; state_d = ST_G2; end
         ST_G2: begin c_d = g_use_s; state_d = ST_G3; end
         ST_G3: begin
`endif
            d_d         = g_use_s;
            c_d         = c_q + g_use_s;
            d_out_d     = g_use_s;
            c_out_d     = c_q + g_use_s;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_DONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State, working halves and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         c_q         <= 32'd0;
         d_q         <= 32'd0;
         c_out_q     <= 32'd0;
         d_out_q     <= 32'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         d_q         <= d_d;
         c_out_q     <= c_out_d;
         d_out_q     <= d_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign c_out     = c_out_q;
   assign d_out     = d_out_q;
endmodule

// File: tb/tb_seed_f_round.sv
// tb_seed_f_round: scoreboard bench for seed_f_round against a reference-style SEED F() model.
// Build with SEED_F_REG_G_EN defined to exercise the registered-G variant.
module tb_seed_f_round;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0] c_in, d_in, k0, k1, c_out, d_out;

   int total = 0;
   int bad   = 0;
   logic [63:0] sb_q [$];
   logic [63:0] zero_exp;

`ifdef SEED_F_REG_G_EN
   localparam int LAT = 7;
   localparam int MID_EDGES = 3;
`else
   localparam int LAT = 4;
   localparam int MID_EDGES = 2;
`endif

   localparam logic [7:0] S1_T [256] = '{
      8'd169,8'd133,8'd214,8'd211,8'd84,8'd29,8'd172,8'd37,8'd93,8'd67,8'd24,8'd30,8'd81,8'd252,8'd202,8'd99,
      8'd40,8'd68,8'd32,8'd157,8'd224,8'd226,8'd200,8'd23,8'd165,8'd143,8'd3,8'd123,8'd187,8'd19,8'd210,8'd238,
      8'd112,8'd140,8'd63,8'd168,8'd50,8'd221,8'd246,8'd116,8'd236,8'd149,8'd11,8'd87,8'd92,8'd91,8'd189,8'd1,
      8'd36,8'd28,8'd115,8'd152,8'd16,8'd204,8'd242,8'd217,8'd44,8'd231,8'd114,8'd131,8'd155,8'd209,8'd134,8'd201,
      8'd96,8'd80,8'd163,8'd235,8'd13,8'd182,8'd158,8'd79,8'd183,8'd90,8'd198,8'd120,8'd166,8'd18,8'd175,8'd213,
      8'd97,8'd195,8'd180,8'd65,8'd82,8'd125,8'd141,8'd8,8'd31,8'd153,8'd0,8'd25,8'd4,8'd83,8'd247,8'd225,
      8'd253,8'd118,8'd47,8'd39,8'd176,8'd139,8'd14,8'd171,8'd162,8'd110,8'd147,8'd77,8'd105,8'd124,8'd9,8'd10,
      8'd191,8'd239,8'd243,8'd197,8'd135,8'd20,8'd254,8'd100,8'd222,8'd46,8'd75,8'd26,8'd6,8'd33,8'd107,8'd102,
      8'd2,8'd245,8'd146,8'd138,8'd12,8'd179,8'd126,8'd208,8'd122,8'd71,8'd150,8'd229,8'd38,8'd128,8'd173,8'd223,
      8'd161,8'd48,8'd55,8'd174,8'd54,8'd21,8'd34,8'd56,8'd244,8'd167,8'd69,8'd76,8'd129,8'd233,8'd132,8'd151,
      8'd53,8'd203,8'd206,8'd60,8'd113,8'd17,8'd199,8'd137,8'd117,8'd251,8'd218,8'd248,8'd148,8'd89,8'd130,8'd196,
      8'd255,8'd73,8'd57,8'd103,8'd192,8'd207,8'd215,8'd184,8'd15,8'd142,8'd66,8'd35,8'd145,8'd108,8'd219,8'd164,
      8'd52,8'd241,8'd72,8'd194,8'd111,8'd61,8'd45,8'd64,8'd190,8'd62,8'd188,8'd193,8'd170,8'd186,8'd78,8'd85,
      8'd59,8'd220,8'd104,8'd127,8'd156,8'd216,8'd74,8'd86,8'd119,8'd160,8'd237,8'd70,8'd181,8'd43,8'd101,8'd250,
      8'd227,8'd185,8'd177,8'd159,8'd94,8'd249,8'd230,8'd178,8'd49,8'd234,8'd109,8'd95,8'd228,8'd240,8'd205,8'd136,
      8'd22,8'd58,8'd88,8'd212,8'd98,8'd41,8'd7,8'd51,8'd232,8'd27,8'd5,8'd121,8'd144,8'd106,8'd42,8'd154};

   localparam logic [7:0] S2_T [256] = '{
      8'd56,8'd232,8'd45,8'd166,8'd207,8'd222,8'd179,8'd184,8'd175,8'd96,8'd85,8'd199,8'd68,8'd111,8'd107,8'd91,
      8'd195,8'd98,8'd51,8'd181,8'd41,8'd160,8'd226,8'd167,8'd211,8'd145,8'd17,8'd6,8'd28,8'd188,8'd54,8'd75,
      8'd239,8'd136,8'd108,8'd168,8'd23,8'd196,8'd22,8'd244,8'd194,8'd69,8'd225,8'd214,8'd63,8'd61,8'd142,8'd152,
      8'd40,8'd78,8'd246,8'd62,8'd165,8'd249,8'd13,8'd223,8'd216,8'd43,8'd102,8'd122,8'd39,8'd47,8'd241,8'd114,
      8'd66,8'd212,8'd65,8'd192,8'd115,8'd103,8'd172,8'd139,8'd247,8'd173,8'd128,8'd31,8'd202,8'd44,8'd170,8'd52,
      8'd210,8'd11,8'd238,8'd233,8'd93,8'd148,8'd24,8'd248,8'd87,8'd174,8'd8,8'd197,8'd19,8'd205,8'd134,8'd185,
      8'd255,8'd125,8'd193,8'd49,8'd245,8'd138,8'd106,8'd177,8'd209,8'd32,8'd215,8'd2,8'd34,8'd4,8'd104,8'd113,
      8'd7,8'd219,8'd157,8'd153,8'd97,8'd190,8'd230,8'd89,8'd221,8'd81,8'd144,8'd220,8'd154,8'd163,8'd171,8'd208,
      8'd129,8'd15,8'd71,8'd26,8'd227,8'd236,8'd141,8'd191,8'd150,8'd123,8'd92,8'd162,8'd161,8'd99,8'd35,8'd77,
      8'd200,8'd158,8'd156,8'd58,8'd12,8'd46,8'd186,8'd110,8'd159,8'd90,8'd242,8'd146,8'd243,8'd73,8'd120,8'd204,
      8'd21,8'd251,8'd112,8'd117,8'd127,8'd53,8'd16,8'd3,8'd100,8'd109,8'd198,8'd116,8'd213,8'd180,8'd234,8'd9,
      8'd118,8'd25,8'd254,8'd64,8'd18,8'd224,8'd189,8'd5,8'd250,8'd1,8'd240,8'd42,8'd94,8'd169,8'd86,8'd67,
      8'd133,8'd20,8'd137,8'd155,8'd176,8'd229,8'd72,8'd121,8'd151,8'd252,8'd30,8'd130,8'd33,8'd140,8'd27,8'd95,
      8'd119,8'd84,8'd178,8'd29,8'd37,8'd79,8'd0,8'd70,8'd237,8'd88,8'd82,8'd235,8'd126,8'd218,8'd201,8'd253,
      8'd48,8'd149,8'd101,8'd60,8'd182,8'd228,8'd187,8'd124,8'd14,8'd80,8'd57,8'd38,8'd50,8'd132,8'd105,8'd147,
      8'd55,8'd231,8'd36,8'd164,8'd203,8'd83,8'd10,8'd135,8'd217,8'd76,8'd131,8'd143,8'd206,8'd59,8'd74,8'd183};

   seed_f_round dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .c_in(c_in), .d_in(d_in), .k0(k0), .k1(k1),
      .out_valid(out_valid), .out_ready(out_ready),
      .c_out(c_out), .d_out(d_out), .busy(busy));

   always #5 clk = ~clk;

   // G written byte-lane by byte-lane (Z3..Z0) as in the SEED reference
   function automatic logic [31:0] g_model(input logic [31:0] x);
      logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
      y0 = S1_T[x[7:0]];   y1 = S2_T[x[15:8]];
      y2 = S1_T[x[23:16]]; y3 = S2_T[x[31:24]];
      z3 = (y0 & 8'h3f) ^ (y1 & 8'hfc) ^ (y2 & 8'hf3) ^ (y3 & 8'hcf);
      z2 = (y0 & 8'hcf) ^ (y1 & 8'h3f) ^ (y2 & 8'hfc) ^ (y3 & 8'hf3);
      z1 = (y0 & 8'hf3) ^ (y1 & 8'hcf) ^ (y2 & 8'h3f) ^ (y3 & 8'hfc);
      z0 = (y0 & 8'hfc) ^ (y1 & 8'hf3) ^ (y2 & 8'hcf) ^ (y3 & 8'h3f);
      return {z3, z2, z1, z0};
   endfunction

   function automatic logic [63:0] f_model(input logic [31:0] c, d, a, b);
      logic [31:0] cc, dd;
      cc = c ^ a;  dd = d ^ b;  dd = dd ^ cc;
      dd = g_model(dd);  cc = cc + dd;
      cc = g_model(cc);  dd = dd + cc;
      dd = g_model(dd);  cc = cc + dd;
      return {cc, dd};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Each negedge with valid&ready precedes exactly one transfer edge
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            chk("result", {c_out, d_out}, sb_q.pop_front());
         end
      end
   end

   task automatic run_op(input logic [31:0] c, d, a, b, input logic [63:0] exp, input int hold);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("in_ready", 64'(in_ready), 64'd1);
      c_in = c; d_in = d; k0 = a; k1 = b;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      sb_q.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         in_valid = (hold != 0) && n[0];
         c_in = $urandom; d_in = $urandom;
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 64'(n), 64'(LAT));
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0]; c_in = $urandom; k0 = $urandom;
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_data", {c_out, d_out}, (sb_q.size() != 0) ? sb_q[0] : 64'd0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_xfer_valid", 64'(out_valid), 64'd0);
      chk("post_xfer_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rc, rd, ra, rb;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      c_in = 32'd0; d_in = 32'd0; k0 = 32'd0; k1 = 32'd0;
      zero_exp = f_model(32'd0, 32'd0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_c_out", 64'(c_out), 64'd0);
      chk("rst_d_out", 64'(d_out), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      run_op(32'd0, 32'd0, 32'd0, 32'd0, zero_exp, 0);
      // Matching key words cancel the data, so the result must equal the all-zero case
      run_op(32'hA5A5A5A5, 32'h3C3C3C3C, 32'hA5A5A5A5, 32'h3C3C3C3C, zero_exp, 0);
      run_op(32'hFFFFFFFF, 32'h00000001, 32'd0, 32'd0, f_model(32'hFFFFFFFF, 32'd1, 32'd0, 32'd0), 0);
      run_op(32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE,
             f_model(32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE), 0);
      rc = $urandom; rd = $urandom; ra = $urandom; rb = $urandom;
      run_op(rc, rd, ra, rb, f_model(rc, rd, ra, rb), 10);

      for (int i = 0; i < 1000; i++) begin
         rc = $urandom; rd = $urandom; ra = $urandom; rb = $urandom;
         run_op(rc, rd, ra, rb, f_model(rc, rd, ra, rb), (i % 97 == 5) ? 3 : 0);
      end

      c_in = $urandom; d_in = $urandom; k0 = $urandom; k1 = $urandom;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (MID_EDGES - 1) begin @(posedge clk); #1; end
      chk("mid_busy_before", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_out_valid", 64'(out_valid), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_c_out", 64'(c_out), 64'd0);
      chk("mid_d_out", 64'(d_out), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("mid_no_valid", 64'(out_valid), 64'd0);
         chk("mid_idle", 64'(in_ready), 64'd1);
      end
      run_op(32'd0, 32'd0, 32'd0, 32'd0, zero_exp, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
